// File: rtl/pow_n_pipelined.sv
// Pipelined n**POW mod 2**W with valid/ready output handshake and global clock enable.
// Optional overflow tracking is built when POW_N_PIPELINED_OVF_EN is defined.
module pow_n_pipelined #(
   parameter int W   = 8,
   parameter int POW = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         n_vld,
   output logic         n_rdy,
   input  logic [W-1:0] n,
   output logic         res_vld,
   input  logic         res_rdy,
   output logic [W-1:0] res,
   output logic         res_ovf
);

   // Handshake: n is taken on a rising edge when n_vld & n_rdy; res is taken
   // when res_vld & res_rdy & clk_en. The whole pipeline moves as one on adv.
   logic           adv;
   logic [POW-1:0] vld_q, vld_d;
   logic [W-1:0]   n_q [POW];
   logic [W-1:0]   n_d [POW];
   logic [W-1:0]   p_q [POW];
   logic [W-1:0]   p_d [POW];

   assign adv     = clk_en & (~vld_q[POW-1] | res_rdy);
   assign n_rdy   = adv;
   assign res_vld = vld_q[POW-1];
   assign res     = p_q[POW-1];

   always_comb begin
      vld_d = vld_q;
      n_d   = n_q;
      p_d   = p_q;
      if (adv) begin
         vld_d[0] = n_vld;
         n_d[0]   = n;
         p_d[0]   = n;
         for (int k = 1; k < POW; k++) begin
            vld_d[k] = vld_q[k-1];
            n_d[k]   = n_q[k-1];
            p_d[k]   = p_q[k-1] * n_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Operand and product registers carry no reset; vld qualifies them.
   always_ff @(posedge clk) begin
      n_q <= n_d;
      p_q <= p_d;
   end

`ifdef POW_N_PIPELINED_OVF_EN
   localparam int W2 = 2 * W;
   logic [POW-1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (adv) begin
         ovf_d[0] = 1'b0;
         for (int k = 1; k < POW; k++) begin
            ovf_d[k] = ovf_q[k-1] |
                       (((W2'(p_q[k-1]) * W2'(n_q[k-1])) >> W) != '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign res_ovf = ovf_q[POW-1];
`else
   assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pow_n_pipelined.sv
// Directed bench for pow_n_pipelined (W=8/POW=5 main instance, W=4/POW=1 side instance).
module tb_pow_n_pipelined;
   localparam int W   = 8;
   localparam int POW = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_en;
   logic         n_vld;
   logic         n_rdy;
   logic [W-1:0] n;
   logic         res_vld;
   logic         res_rdy;
   logic [W-1:0] res;
   logic         res_ovf;

   logic         n2_vld;
   logic         n2_rdy;
   logic [3:0]   n2;
   logic         r2_vld;
   logic [3:0]   r2;
   logic         r2_ovf;

   always #5 clk = ~clk;

   pow_n_pipelined #(.W(W), .POW(POW)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .n_vld(n_vld), .n_rdy(n_rdy), .n(n),
      .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_ovf(res_ovf)
   );

   pow_n_pipelined #(.W(4), .POW(1)) dut1 (
      .clk(clk), .rst(rst), .clk_en(1'b1),
      .n_vld(n2_vld), .n_rdy(n2_rdy), .n(n2),
      .res_vld(r2_vld), .res_rdy(1'b1), .res(r2), .res_ovf(r2_ovf)
   );

   int             errors = 0;
   int             checks = 0;
   int             cyc    = 0;
   logic [8:0]     exp_q[$];
   int             acc_q[$];
   logic [POW-1:0] mvld;
   logic           lat_chk;
   logic [7:0]     tab [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ovf(input logic [7:0] nv);
`ifdef POW_N_PIPELINED_OVF_EN
      return (nv >= 8'd4);
`else
      return (nv == 8'hff);
`endif
   endfunction

   // One clock cycle: drive at negedge, check mid-low-phase, then take the edge.
   task automatic cycle(input logic vld, input logic [7:0] nv, input logic rdy,
                        input logic en, output logic acc);
      logic adv_m;
      @(negedge clk);
      n_vld   = vld;
      n       = nv;
      res_rdy = rdy;
      clk_en  = en;
      #1;
      adv_m = en & (~mvld[POW-1] | rdy);
      chk("n_rdy", {31'd0, n_rdy}, {31'd0, adv_m});
      chk("res_vld", {31'd0, res_vld}, {31'd0, mvld[POW-1]});
      if (mvld[POW-1]) begin
         if (exp_q.size() == 0) begin
            chk("stale_res", {31'd0, res_vld}, 32'd0);
         end else begin
            chk("res", {23'd0, res_ovf, res}, {23'd0, exp_q[0]});
            if (rdy && en) begin
               if (lat_chk) chk("latency", cyc - acc_q[0], POW);
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
            end
         end
      end
      acc = vld & adv_m;
      if (acc) begin
         exp_q.push_back({exp_ovf(nv), tab[nv[3:0]]});
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      if (adv_m) mvld = {mvld[POW-2:0], vld};
      cyc++;
   endtask

   task automatic idle(input int num);
      logic acc;
      for (int j = 0; j < num; j++) cycle(1'b0, 8'd0, 1'b1, 1'b1, acc);
   endtask

   task automatic stream(input int stall_lo, input int stall_hi,
                         input int frz_lo, input int frz_hi);
      int   i;
      int   k;
      logic acc;
      logic rdy;
      logic en;
      i = 0;
      k = 0;
      while (i < 16 && k < 200) begin
         rdy = !(k >= stall_lo && k <= stall_hi);
         en  = !(k >= frz_lo && k <= frz_hi);
         cycle(1'b1, i[7:0], rdy, en, acc);
         if (acc) i++;
         k++;
      end
      chk("stream_sent", i, 16);
      idle(POW + 2);
      chk("stream_drain", exp_q.size(), 0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      n_vld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_res_vld", {31'd0, res_vld}, 32'd0);
      chk("rst_res_ovf", {31'd0, res_ovf}, 32'd0);
      chk("rst_n_rdy", {31'd0, n_rdy}, 32'd1);
      mvld = '0;
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic acc;
      tab = '{8'd0, 8'd1, 8'd32, 8'd243, 8'd0, 8'd53, 8'd96, 8'd167,
              8'd0, 8'd169, 8'd160, 8'd27, 8'd0, 8'd93, 8'd224, 8'd79};
      rst     = 1'b0;
      clk_en  = 1'b0;
      n_vld   = 1'b0;
      n       = '0;
      res_rdy = 1'b1;
      n2_vld  = 1'b0;
      n2      = '0;
      mvld    = '0;
      lat_chk = 1'b0;

      // Reset state, with and without clock enable.
      #3 rst = 1'b1;
      #1;
      chk("init_res_vld", {31'd0, res_vld}, 32'd0);
      chk("init_res_ovf", {31'd0, res_ovf}, 32'd0);
      chk("init_n_rdy_en0", {31'd0, n_rdy}, 32'd0);
      clk_en = 1'b1;
      #1;
      chk("init_n_rdy_en1", {31'd0, n_rdy}, 32'd1);
      chk("init_r2_vld", {31'd0, r2_vld}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single operands with exact latency.
      lat_chk = 1'b1;
      cycle(1'b1, 8'd3, 1'b1, 1'b1, acc);
      chk("accept_3", {31'd0, acc}, 32'd1);
      idle(POW + 2);
      chk("drain_3", exp_q.size(), 0);
      cycle(1'b1, 8'd4, 1'b1, 1'b1, acc);
      idle(POW + 2);
      chk("drain_4", exp_q.size(), 0);

      // Back-to-back stream, full throughput.
      stream(-1, -1, -1, -1);
      lat_chk = 1'b0;

      // Consumer backpressure for 3 cycles mid-stream.
      stream(8, 10, -1, -1);

      // Clock enable low for 4 cycles mid-stream.
      stream(-1, -1, 7, 10);

      // Backpressure and freeze overlapping.
      stream(6, 8, 8, 11);

      // Async reset with 3 operands in flight; nothing stale may emerge.
      cycle(1'b1, 8'd5, 1'b1, 1'b1, acc);
      cycle(1'b1, 8'd6, 1'b1, 1'b1, acc);
      cycle(1'b1, 8'd7, 1'b1, 1'b1, acc);
      async_reset();
      idle(POW + 3);
      lat_chk = 1'b1;
      cycle(1'b1, 8'd9, 1'b1, 1'b1, acc);
      idle(POW + 2);
      chk("drain_post_rst", exp_q.size(), 0);

      // POW=1, W=4 instance.
      @(negedge clk);
      n2_vld = 1'b1;
      n2     = 4'd13;
      #1;
      chk("p1_n_rdy", {31'd0, n2_rdy}, 32'd1);
      @(negedge clk);
      n2_vld = 1'b1;
      n2     = 4'd1;
      #1;
      chk("p1_vld_13", {31'd0, r2_vld}, 32'd1);
      chk("p1_res_13", {28'd0, r2}, 32'd13);
      chk("p1_ovf_13", {31'd0, r2_ovf}, 32'd0);
      @(negedge clk);
      n2_vld = 1'b0;
      #1;
      chk("p1_vld_1", {31'd0, r2_vld}, 32'd1);
      chk("p1_res_1", {28'd0, r2}, 32'd1);
      @(negedge clk);
      #1;
      chk("p1_vld_idle", {31'd0, r2_vld}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
